uart_rx_ctrl: RTL and testbench

Parametrised UART receive controller: detects start bits, times bit periods internally, samples and shifts serial data LSB-first, checks stop bits, and presents received words with ready, framing and overrun status. It replaces the fixed 8N1 control unit plus its external timer and bit counter with one configurable block. It sits between the input synchronizer and the receive buffer/host interface.

---
 rtl/uart_rx_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: parametrised UART receiver with internal bit timing, stop-bit
// checking and ready/framing/overrun/parity status for the host side.
// Optional parity stage is built only when UART_RX_PARITY_EN is defined;
// otherwise parity_error is tied low and the frame is start + data + stop.
module uart_rx_ctrl #(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned CLKS_PER_BIT = 10,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 serial_in,
    input  logic                 data_read,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 data_ready,
    output logic                 framing_error,
    output logic                 overrun_error,
    output logic                 parity_error,
    output logic                 busy
);

    localparam int unsigned TMR_W = 16;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned HALF  = CLKS_PER_BIT / 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_LOAD
    } state_t;

    // Reject parameter sets outside the supported range at elaboration
    if (DATA_BITS < 5 || DATA_BITS > 9 || CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65534 ||
        (CLKS_PER_BIT % 2) != 0 || STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD > 1) begin : g_bad_cfg
        $error("uart_rx_ctrl: illegal parameter set");
    end

    state_t               r_state;
    logic [TMR_W-1:0]     r_tmr;
    logic [CNT_W-1:0]     r_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_hist;
    logic                 r_frame_bad;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_data_ready;
    logic                 r_framing_error;
    logic                 r_overrun_error;
    logic                 r_busy;

    logic                 w_half_hit;
    logic                 w_bit_hit;
    logic                 w_parity_bad;
    logic                 w_frame_good;

    assign w_half_hit   = (r_tmr == TMR_W'(HALF - 1));
    assign w_bit_hit    = (r_tmr == TMR_W'(CLKS_PER_BIT - 1));
    assign w_frame_good = !r_frame_bad && !w_parity_bad;

`ifdef UART_RX_PARITY_EN
    logic r_par_bit;
    logic r_parity_error;

    // Parity mismatch: sampled bit differs from XOR of data (inverted for odd)
    assign w_parity_bad = r_par_bit ^ (^r_shift) ^ 1'(PARITY_ODD);
    assign parity_error = r_parity_error;
`else
    assign w_parity_bad = 1'b0;
    assign parity_error = 1'b0;
`endif

    assign rx_data       = r_rx_data;
    assign data_ready    = r_data_ready;
    assign framing_error = r_framing_error;
    assign overrun_error = r_overrun_error;
    assign busy          = r_busy;

    // Receive FSM, bit timer, shift register and host status flags
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state         <= S_IDLE;
            r_tmr           <= '0;
            r_cnt           <= '0;
            r_shift         <= '0;
            r_hist          <= 1'b0;
            r_frame_bad     <= 1'b0;
            r_rx_data       <= '0;
            r_data_ready    <= 1'b0;
            r_framing_error <= 1'b0;
            r_overrun_error <= 1'b0;
            r_busy          <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bit       <= 1'b0;
            r_parity_error  <= 1'b0;
`endif
        end else begin
            r_hist <= serial_in;
            // Host read; a good LOAD in the same cycle overrides below
            if (data_read) begin
                r_data_ready    <= 1'b0;
                r_overrun_error <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    r_tmr <= '0;
                    r_cnt <= '0;
                    if (r_hist && !serial_in) begin
                        r_state <= S_START;
                        r_busy  <= 1'b1;
                    end
                end
                S_START: begin
                    if (w_half_hit) begin
                        r_tmr       <= '0;
                        r_frame_bad <= 1'b0;
                        if (serial_in) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= S_DATA;
                            r_cnt   <= '0;
                        end
                    end else begin
                        r_tmr <= r_tmr + TMR_W'(1);
                    end
                end
                S_DATA: begin
                    if (w_bit_hit) begin
                        r_tmr   <= '0;
                        r_shift <= {serial_in, r_shift[DATA_BITS-1:1]};
                        if (r_cnt == CNT_W'(DATA_BITS - 1)) begin
                            r_cnt   <= '0;
`ifdef UART_RX_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end else begin
                        r_tmr <= r_tmr + TMR_W'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (w_bit_hit) begin
                        r_tmr     <= '0;
                        r_par_bit <= serial_in;
                        r_state   <= S_STOP;
                    end else begin
                        r_tmr <= r_tmr + TMR_W'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (w_bit_hit) begin
                        r_tmr <= '0;
                        if (!serial_in) begin
                            r_frame_bad <= 1'b1;
                        end
                        if (r_cnt == CNT_W'(STOP_BITS - 1)) begin
                            r_cnt   <= '0;
                            r_state <= S_LOAD;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end else begin
                        r_tmr <= r_tmr + TMR_W'(1);
                    end
                end
                S_LOAD: begin
                    r_state         <= S_IDLE;
                    r_busy          <= 1'b0;
                    r_tmr           <= '0;
                    r_framing_error <= r_frame_bad;
`ifdef UART_RX_PARITY_EN
                    r_parity_error  <= w_parity_bad;
`endif
                    if (w_frame_good) begin
                        r_rx_data       <= r_shift;
                        r_data_ready    <= 1'b1;
                        r_overrun_error <= !data_read && (r_data_ready || r_overrun_error);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_tmr   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed test-plan frames followed by
// random frames, all compared against a frame-level reference model.
module tb_uart_rx_ctrl;

`ifdef UART_RX_PARITY_EN
    localparam int DB   = 7;
    localparam int PODD = 1;
    localparam int P    = 1;
`else
    localparam int DB   = 8;
    localparam int PODD = 0;
    localparam int P    = 0;
`endif
    localparam int CPB      = 10;
    localparam int SB       = 1;
    localparam int HALF     = CPB / 2;
    localparam int NBITS    = DB + P + SB;
    localparam int LOAD_CYC = HALF + NBITS * CPB + 1;
    localparam int LAT      = LOAD_CYC + 1;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          serial_in;
    logic          data_read;
    logic [DB-1:0] rx_data;
    logic          data_ready;
    logic          framing_error;
    logic          overrun_error;
    logic          parity_error;
    logic          busy;

    int checks = 0;
    int errors = 0;

    // Reference model state (host-visible outputs)
    logic [DB-1:0] m_data;
    logic          m_dr, m_fe, m_ov, m_pe;

    uart_rx_ctrl #(
        .DATA_BITS   (DB),
        .CLKS_PER_BIT(CPB),
        .STOP_BITS   (SB),
        .PARITY_ODD  (PODD)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .serial_in    (serial_in),
        .data_read    (data_read),
        .rx_data      (rx_data),
        .data_ready   (data_ready),
        .framing_error(framing_error),
        .overrun_error(overrun_error),
        .parity_error (parity_error),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".rx_data"}, 16'(rx_data), 16'(m_data));
        check({tag, ".data_ready"}, 16'(data_ready), 16'(m_dr));
        check({tag, ".framing_error"}, 16'(framing_error), 16'(m_fe));
        check({tag, ".overrun_error"}, 16'(overrun_error), 16'(m_ov));
        check({tag, ".parity_error"}, 16'(parity_error), 16'(m_pe));
    endtask

    function automatic logic good_parity(input logic [DB-1:0] d);
        return (^d) ^ 1'(PODD);
    endfunction

    // Frame-level model: outcome of one completed frame as seen by the host
    task automatic model_frame(input logic [DB-1:0] d, input logic stop_ok,
                               input logic par_ok, input logic read_at_load);
        logic good;
        good = stop_ok && (P == 0 || par_ok);
        m_fe = !stop_ok;
        m_pe = (P == 1) && !par_ok;
        if (good) begin
            m_ov   = read_at_load ? 1'b0 : (m_dr || m_ov);
            m_dr   = 1'b1;
            m_data = d;
        end else if (read_at_load) begin
            m_dr = 1'b0;
            m_ov = 1'b0;
        end
    endtask

    task automatic model_read();
        m_dr = 1'b0;
        m_ov = 1'b0;
    endtask

    task automatic pulse_read();
        data_read = 1'b1;
        tick();
        data_read = 1'b0;
        model_read();
    endtask

    // Drive one frame bit by bit; report cycles (from the edge cycle) of
    // data_ready rising and busy rising/falling
    task automatic send_frame(input logic [DB-1:0] d, input logic par, input logic stop,
                              input int read_at, output int rdy_cyc,
                              output int busy_rise, output int busy_fall);
        logic bits[$];
        logic prev_dr, prev_busy;
        int   total;
        bits.delete();
        bits.push_back(1'b0);
        for (int i = 0; i < DB; i++) bits.push_back(d[i]);
        if (P == 1) bits.push_back(par);
        for (int i = 0; i < SB; i++) bits.push_back(stop);
        total     = bits.size() * CPB + 2;
        rdy_cyc   = -1;
        busy_rise = -1;
        busy_fall = -1;
        prev_dr   = data_ready;
        prev_busy = busy;
        for (int j = 0; j < total; j++) begin
            serial_in = (j < bits.size() * CPB) ? bits[j / CPB] : 1'b1;
            data_read = (j == read_at);
            tick();
            if (!prev_dr && data_ready && rdy_cyc < 0) rdy_cyc = j + 1;
            if (!prev_busy && busy && busy_rise < 0) busy_rise = j + 1;
            if (prev_busy && !busy && busy_fall < 0) busy_fall = j + 1;
            prev_dr   = data_ready;
            prev_busy = busy;
        end
        data_read = 1'b0;
    endtask

    task automatic frame(input logic [DB-1:0] d, input logic par, input logic stop, input int read_at);
        int r, br, bf;
        send_frame(d, par, stop, read_at, r, br, bf);
        model_frame(d, stop, par == good_parity(d), read_at == LOAD_CYC);
    endtask

    initial begin
        int            r, br, bf;
        logic [DB-1:0] d;
        logic          busy_seen;

        n_rst     = 1'b0;
        serial_in = 1'b1;
        data_read = 1'b0;
        m_data = '0; m_dr = 1'b0; m_fe = 1'b0; m_ov = 1'b0; m_pe = 1'b0;
        repeat (3) tick();
        check_all("reset");
        check("reset.busy", 16'(busy), 16'(0));
        n_rst = 1'b1;
        repeat (5) tick();

        // First good frame with latency and busy window
        d = DB'(8'hA5);
        send_frame(d, good_parity(d), 1'b1, -1, r, br, bf);
        model_frame(d, 1'b1, 1'b1, 1'b0);
        check_all("first");
        check("first.ready_latency", 16'(r), 16'(LAT));
        check("first.busy_rise", 16'(br), 16'(1));
        check("first.busy_fall", 16'(bf), 16'(LAT));
        check("first.busy_after", 16'(busy), 16'(0));

        // Short low glitch: false start, nothing changes
        serial_in = 1'b0;
        repeat (3) tick();
        serial_in = 1'b1;
        repeat (20) tick();
        check_all("glitch");
        check("glitch.busy", 16'(busy), 16'(0));

        // Bad stop bit, then a good frame
        pulse_read();
        check_all("read1");
        d = DB'(8'h3C);
        frame(d, good_parity(d), 1'b0, -1);
        check_all("framing");
        repeat (3) tick();
        d = DB'(8'h5A);
        frame(d, good_parity(d), 1'b1, -1);
        check_all("after_framing");

        // Overrun, read clears, read coincident with LOAD
        pulse_read();
        d = DB'(8'h11);
        frame(d, good_parity(d), 1'b1, -1);
        d = DB'(8'h22);
        frame(d, good_parity(d), 1'b1, -1);
        check_all("overrun");
        pulse_read();
        check_all("overrun_cleared");
        d = DB'(8'h33);
        frame(d, good_parity(d), 1'b1, -1);
        d = DB'(8'h44);
        frame(d, good_parity(d), 1'b1, LOAD_CYC);
        check_all("read_at_load");

`ifdef UART_RX_PARITY_EN
        // Odd parity on 0x41: parity 1 accepted, parity 0 rejected
        pulse_read();
        frame(DB'(8'h41), 1'b1, 1'b1, -1);
        check_all("parity_ok");
        frame(DB'(8'h41), 1'b0, 1'b1, -1);
        check_all("parity_bad");
`endif

        // Random frames with random stop/parity faults and reads
        for (int k = 0; k < 10; k++) begin
            int   mode;
            logic stop, par;
            d    = DB'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            par  = good_parity(d) ^ (($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
            mode = $urandom_range(0, 2);
            frame(d, par, stop, (mode == 1) ? LOAD_CYC : -1);
            check_all($sformatf("rand%0d", k));
            if (mode == 2) begin
                pulse_read();
                check_all($sformatf("rand%0d_read", k));
            end
            repeat ($urandom_range(0, 4)) tick();
        end

        // Reset in mid data bit 4 with line low; no start until high then low
        d = DB'(8'hC3);
        frame(d, good_parity(d), 1'b1, -1);
        serial_in = 1'b0;
        repeat (5 * CPB + HALF) tick();
        n_rst = 1'b0;
        repeat (2) tick();
        m_data = '0; m_dr = 1'b0; m_fe = 1'b0; m_ov = 1'b0; m_pe = 1'b0;
        check_all("midreset");
        check("midreset.busy", 16'(busy), 16'(0));
        n_rst     = 1'b1;
        busy_seen = 1'b0;
        for (int j = 0; j < 3 * CPB; j++) begin
            tick();
            if (busy) busy_seen = 1'b1;
        end
        check("midreset.no_start", 16'(busy_seen), 16'(0));
        check_all("midreset_low");
        serial_in = 1'b1;
        repeat (5) tick();
        d = DB'(8'h96);
        frame(d, good_parity(d), 1'b1, -1);
        check_all("post_reset_frame");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
